// File: rtl/d16_pkg.sv
// Shared d16 definitions: ALU opcodes used by the ALU, decoder and multiply controller,
// plus the multiply sequencer state encodings.
package d16_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SHL = 4'b0011;
    localparam logic [3:0] ALU_SHR = 4'b0100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        SHL   = 3'd2,
        SHR   = 3'd3,
        DONE  = 3'd4,
        NEG_A = 3'd5,
        NEG_B = 3'd6,
        NEG_R = 3'd7
    } mul_state_e;

    // Signed magnitude range: +0x7FFF for a positive product, 0x8000 for a negative one.
    function automatic logic mag_ovf(input logic [15:0] mag, input logic neg);
        return neg ? (mag > 16'h8000) : mag[15];
    endfunction

endpackage

// File: rtl/d16_mul_ctrl.sv
// Shift-add 16x16 multiply sequencer driving the external d16 ALU, one op per cycle.
// Optional signed operation is enabled by defining D16_MUL_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start, ALU NOP
// STEP  | add mc into acc if mp[0]; finish when mp == 0
// SHL   | mc <= mc << 1, track bits lost off the top
// SHR   | mp <= mp >> 1
// DONE  | publish result/ovf, one-cycle done pulse
// NEG_A | mc <= 0 - mc (signed, negative multiplicand)
// NEG_B | mp <= 0 - mp (signed, negative multiplier)
// NEG_R | acc <= 0 - acc (signed, negative product)
module d16_mul_ctrl
    import d16_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
`ifdef D16_MUL_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_s
);

    mul_state_e state, state_nxt;

    logic [15:0] acc, acc_nxt;
    logic [15:0] mc, mc_nxt;
    logic [15:0] mp, mp_nxt;
    logic        lost, lost_nxt;
    logic        ovf_run, ovf_run_nxt;
    logic [15:0] result_nxt;
    logic        ovf_nxt;
`ifdef D16_MUL_SIGNED_EN
    logic        sgn, sgn_nxt;
    logic        sgn_mode, sgn_mode_nxt;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            acc      <= '0;
            mc       <= '0;
            mp       <= '0;
            lost     <= 1'b0;
            ovf_run  <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
`ifdef D16_MUL_SIGNED_EN
            sgn      <= 1'b0;
            sgn_mode <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            mc       <= mc_nxt;
            mp       <= mp_nxt;
            lost     <= lost_nxt;
            ovf_run  <= ovf_run_nxt;
            result   <= result_nxt;
            ovf      <= ovf_nxt;
`ifdef D16_MUL_SIGNED_EN
            sgn      <= sgn_nxt;
            sgn_mode <= sgn_mode_nxt;
`endif
        end
    end

    // ovf_run accumulates during the loop; the visible ovf only moves in DONE.
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        mc_nxt       = mc;
        mp_nxt       = mp;
        lost_nxt     = lost;
        ovf_run_nxt  = ovf_run;
        result_nxt   = result;
        ovf_nxt      = ovf;
        alu_ctrl     = ALU_NOP;
        alu_a        = '0;
        alu_b        = '0;
        busy         = (state != IDLE);
        done         = 1'b0;
`ifdef D16_MUL_SIGNED_EN
        sgn_nxt      = sgn;
        sgn_mode_nxt = sgn_mode;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt     = '0;
                    mc_nxt      = op_a;
                    mp_nxt      = op_b;
                    lost_nxt    = 1'b0;
                    ovf_run_nxt = 1'b0;
                    state_nxt   = STEP;
`ifdef D16_MUL_SIGNED_EN
                    sgn_mode_nxt = signed_op;
                    sgn_nxt      = signed_op & (op_a[15] ^ op_b[15]);
                    if (signed_op && op_a[15])
                        state_nxt = NEG_A;
                    else if (signed_op && op_b[15])
                        state_nxt = NEG_B;
`endif
                end
            end

            STEP: begin
                if (mp == 16'h0000) begin
`ifdef D16_MUL_SIGNED_EN
                    if (sgn_mode)
                        ovf_run_nxt = ovf_run | mag_ovf(acc, sgn);
                    state_nxt = sgn ? NEG_R : DONE;
`else
                    state_nxt = DONE;
`endif
                end else if (mp[0]) begin
                    alu_ctrl    = ALU_ADD;
                    alu_a       = acc;
                    alu_b       = mc;
                    acc_nxt     = alu_s;
                    ovf_run_nxt = ovf_run | lost | (alu_s < acc);
                    state_nxt   = SHL;
                end else begin
                    state_nxt = SHL;
                end
            end

            SHL: begin
                alu_ctrl  = ALU_SHL;
                alu_a     = mc;
                mc_nxt    = alu_s;
                lost_nxt  = lost | mc[15];
                state_nxt = SHR;
            end

            SHR: begin
                alu_ctrl  = ALU_SHR;
                alu_a     = mp;
                mp_nxt    = alu_s;
                state_nxt = STEP;
            end

            DONE: begin
                done       = 1'b1;
                result_nxt = acc;
                ovf_nxt    = ovf_run;
                state_nxt  = IDLE;
            end

`ifdef D16_MUL_SIGNED_EN
            NEG_A: begin
                alu_ctrl  = ALU_SUB;
                alu_b     = mc;
                mc_nxt    = alu_s;
                state_nxt = (sgn_mode && mp[15]) ? NEG_B : STEP;
            end

            NEG_B: begin
                alu_ctrl  = ALU_SUB;
                alu_b     = mp;
                mp_nxt    = alu_s;
                state_nxt = STEP;
            end

            NEG_R: begin
                alu_ctrl  = ALU_SUB;
                alu_b     = acc;
                acc_nxt   = alu_s;
                state_nxt = DONE;
            end
`endif

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_d16_mul_ctrl.sv
// Directed bench for d16_mul_ctrl with a behavioural d16 ALU alongside it.
module tb_d16_mul_ctrl;
    import d16_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
`ifdef D16_MUL_SIGNED_EN
    logic        signed_op = 1'b0;
`endif
    logic        busy, done, ovf;
    logic [15:0] result, alu_a, alu_b, alu_s;
    logic [3:0]  alu_ctrl;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        case (alu_ctrl)
            4'b0001: alu_s = alu_a + alu_b;
            4'b0010: alu_s = alu_a - alu_b;
            4'b0011: alu_s = {alu_a[14:0], 1'b0};
            4'b0100: alu_s = {1'b0, alu_a[15:1]};
            default: alu_s = 16'h0000;
        endcase
    end

    d16_mul_ctrl dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
`ifdef D16_MUL_SIGNED_EN
        .signed_op(signed_op),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s)
    );

    // Caller is at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                          output int lat, output int adds,
                          output logic [15:0] res, output logic ov);
        lat  = 0;
        adds = 0;
        op_a = a;
        op_b = b;
`ifdef D16_MUL_SIGNED_EN
        signed_op = sgn;
`else
        if (sgn) $display("note: signed request issued to an unsigned build");
`endif
        start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (alu_ctrl == ALU_ADD) adds++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_fail++;
            $display("FAIL timeout: no done within 60 cycles for %h*%h", a, b);
        end
        @(negedge sys_clk);
        res = result;
        ov  = ovf;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_ctrl: got %b want 0000", alu_ctrl); end
    endtask

    task automatic test_simple();
        int lat, adds; logic [15:0] res; logic ov;
        do_mul(16'd3, 16'd5, 1'b0, lat, adds, res, ov);
        n_cmp++; if (lat != 11) begin n_fail++; $display("FAIL simple_latency: got %0d want 11", lat); end
        n_cmp++; if (res !== 16'h000F) begin n_fail++; $display("FAIL simple_result: got %h want 000f", res); end
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL simple_ovf: got %b want 0", ov); end
        n_cmp++; if (adds != 2) begin n_fail++; $display("FAIL simple_add_count: got %0d want 2", adds); end
    endtask

    task automatic test_zero_one();
        int lat, adds; logic [15:0] res; logic ov;
        do_mul(16'hFFFF, 16'h0000, 1'b0, lat, adds, res, ov);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
        n_cmp++; if (res !== 16'h0000) begin n_fail++; $display("FAIL zero_result: got %h want 0000", res); end
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL zero_ovf: got %b want 0", ov); end
        do_mul(16'hFFFF, 16'h0001, 1'b0, lat, adds, res, ov);
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL one_latency: got %0d want 5", lat); end
        n_cmp++; if (res !== 16'hFFFF) begin n_fail++; $display("FAIL one_result: got %h want ffff", res); end
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL one_ovf: got %b want 0", ov); end
        do_mul(16'h0001, 16'h8000, 1'b0, lat, adds, res, ov);
        n_cmp++; if (lat != 50) begin n_fail++; $display("FAIL max_latency: got %0d want 50", lat); end
        n_cmp++; if (res !== 16'h8000 || ov !== 1'b0) begin n_fail++; $display("FAIL max_result: got %h/%b want 8000/0", res, ov); end
    endtask

    task automatic test_overflow();
        int lat, adds; logic [15:0] res; logic ov;
        do_mul(16'h8000, 16'h0003, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'h8000) begin n_fail++; $display("FAIL lost_result: got %h want 8000", res); end
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL lost_ovf: got %b want 1", ov); end
        do_mul(16'h6000, 16'h0003, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'h2000) begin n_fail++; $display("FAIL carry_result: got %h want 2000", res); end
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL carry_ovf: got %b want 1", ov); end
        do_mul(16'h0100, 16'h0100, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'h0000) begin n_fail++; $display("FAIL sq256_result: got %h want 0000", res); end
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL sq256_ovf: got %b want 1", ov); end
        n_cmp++; if (lat != 29) begin n_fail++; $display("FAIL sq256_latency: got %0d want 29", lat); end
        do_mul(16'h00FF, 16'h0101, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'hFFFF || ov !== 1'b0) begin n_fail++; $display("FAIL edge_ffff: got %h/%b want ffff/0", res, ov); end
    endtask

    task automatic test_handshake();
        int lat;
        logic [15:0] prev;
        prev = result;
        lat = 0;
        op_a = 16'd7; op_b = 16'd9; start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (i == 3) begin op_a = 16'd100; op_b = 16'd100; start = 1'b1; end
            if (i == 5) begin
                n_cmp++; if (result !== prev) begin n_fail++; $display("FAIL result_stable: got %h want %h", result, prev); end
            end
            if (done) begin
                lat = i;
                op_a = 16'd2; op_b = 16'd2; start = 1'b1;
                break;
            end
        end
        n_cmp++; if (lat != 14) begin n_fail++; $display("FAIL hs_latency: got %0d want 14", lat); end
        @(negedge sys_clk);
        start = 1'b0;
        n_cmp++; if (result !== 16'd63) begin n_fail++; $display("FAIL hs_result: got %0d want 63", result); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored: busy %b want 0", busy); end
    endtask

    task automatic test_abort();
        int lat, adds, seen; logic [15:0] res; logic ov;
        op_a = 16'h1234; op_b = 16'h00FF; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge sys_clk);
            start = 1'b0;
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL abort_result: got %h want 0000", result); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) seen++;
            @(negedge sys_clk);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        do_mul(16'd2, 16'd2, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'd4 || ov !== 1'b0) begin n_fail++; $display("FAIL after_abort: got %h/%b want 0004/0", res, ov); end
        n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL after_abort_latency: got %0d want 8", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, adds; logic [15:0] res; logic ov;
        do_mul(16'd11, 16'd13, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'd143) begin n_fail++; $display("FAIL b2b_first: got %0d want 143", res); end
        do_mul(16'h0400, 16'h0041, 1'b0, lat, adds, res, ov);
        n_cmp++; if (res !== 16'h0400 || ov !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %h/%b want 0400/1", res, ov); end
        n_cmp++; if (lat != 23) begin n_fail++; $display("FAIL b2b_latency: got %0d want 23", lat); end
    endtask

`ifdef D16_MUL_SIGNED_EN
    task automatic test_signed();
        int lat, adds; logic [15:0] res; logic ov;
        do_mul(16'hFFFD, 16'h0005, 1'b1, lat, adds, res, ov);
        n_cmp++; if (res !== 16'hFFF1) begin n_fail++; $display("FAIL signed_result: got %h want fff1", res); end
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL signed_ovf: got %b want 0", ov); end
        n_cmp++; if (lat != 13) begin n_fail++; $display("FAIL signed_latency: got %0d want 13", lat); end
        do_mul(16'h8000, 16'hFFFF, 1'b1, lat, adds, res, ov);
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL signed_ovf_8000: got %b want 1", ov); end
        n_cmp++; if (lat != 7) begin n_fail++; $display("FAIL signed_latency_2neg: got %0d want 7", lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_simple();
        test_zero_one();
        test_overflow();
        test_handshake();
        test_abort();
        test_back_to_back();
`ifdef D16_MUL_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/d16_mul_ctrl.md
Name: d16_mul_ctrl

Overview:
Multi-cycle unsigned 16x16 multiply sequencer built on the shared d16 ALU. It uses the shift-add algorithm and issues one ALU operation per cycle: ADD, SHL or SHR. The ALU itself is instantiated alongside this block; the controller drives the ALU opcode and operands, and samples the combinational sum in the same cycle. It returns the low 16 product bits plus an overflow flag over a start/busy/done handshake.

Parameters:
None. The datapath width is fixed at 16 bits and the ALU opcodes are package constants.

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
start  in  1  request; accepted only in IDLE
op_a  in  16  multiplicand, sampled on accept
op_b  in  16  multiplier, sampled on accept
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, high exactly while state == DONE
result  out  16  low 16 product bits; held until the next accept
ovf  out  1  product >= 2^16 (unsigned); held with result
alu_ctrl  out  4  ALU opcode: 0000 NOP, 0001 ADD, 0011 SHL, 0100 SHR (0010 SUB only with the optional feature)
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_s  in  16  ALU result (combinational, same cycle)

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - acc, mc, mp, result, ovf, lost all go to 0.
  - busy = 0, done = 0, alu_ctrl = 0000, alu_a = alu_b = 0.
- Reset has priority over everything. Reset mid-operation aborts it: no done pulse, and result/ovf are cleared.
- Internal registers:
  - acc: 16-bit accumulator.
  - mc: multiplicand, shifts left.
  - mp: multiplier, shifts right.
  - lost: sticky flag, "a 1 has been shifted out of mc".
- IDLE:
  - ALU outputs are NOP with operands 0.
  - On start=1: acc<=0, mc<=op_a, mp<=op_b, lost<=0, ovf<=0; go to STEP.
- STEP:
  - If mp==0: go to DONE, ALU NOP.
  - Else if mp[0]==1: drive ADD with alu_a=acc, alu_b=mc.
    - acc <= alu_s.
    - ovf <= ovf | lost | (alu_s < acc), where the compare is unsigned and done locally.
    - Go to SHL.
  - Else: ALU NOP, go to SHL.
- SHL:
  - Drive SHL with alu_a=mc, alu_b=0.
  - mc <= alu_s; lost <= lost | mc[15].
  - Go to SHR.
- SHR:
  - Drive SHR with alu_a=mp, alu_b=0.
  - mp <= alu_s; go to STEP.
- DONE:
  - done=1, result <= acc; go to IDLE.
- Latency, counted from the accept edge to the done cycle: 2 + 3*k cycles, where k = (index of the highest set bit of op_b) + 1, and k = 0 when op_b == 0.
  - Maximum latency is 50 cycles.
- Handshake rules:
  - start while busy (including during DONE) is ignored and not queued.
  - A new start may be asserted in the cycle after done.
- result and ovf update only in the DONE cycle. They are stable at all other times.

Optional Feature:
Macro D16_MUL_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), sampled on accept.
  - When signed_op=1, extra state NEG_A runs before the first STEP if op_a[15]=1. It drives SUB with alu_a=0, alu_b=mc, and mc <= alu_s. State NEG_B does the same for mp when op_b[15]=1.
  - The sign is registered as op_a[15]^op_b[15].
  - After the loop, if the sign is 1, state NEG_R negates acc via SUB before DONE.
  - ovf additionally sets when the magnitude exceeds 0x7FFF, or exceeds 0x8000 when the sign is 1.
  - Each negation adds 1 cycle of latency.
- Undefined: the port is absent, SUB is never issued, and behaviour is unsigned-only as above.

Decomposition:
- Package d16_pkg holds:
  - ALU opcode constants: ALU_NOP=4'b0000, ALU_ADD=4'b0001, ALU_SUB=4'b0010, ALU_SHL=4'b0011, ALU_SHR=4'b0100. These are shared with the ALU and the decoder.
  - Controller state encodings: IDLE, STEP, SHL, SHR, DONE, NEG_A, NEG_B, NEG_R.
- No sub-module. A single FSM plus registers; the ALU is external.

Test Plan:
1. Reset.
   - Stimulus: assert sys_rst for 2 cycles, then release.
   - Response: busy=0, done=0, result=0, ovf=0, alu_ctrl=0000.
2. Simple multiply.
   - Stimulus: op_a=3, op_b=5, start.
   - Response: done 11 cycles after accept; result=0x000F, ovf=0; exactly two ADD cycles seen on alu_ctrl.
3. Zero and one multipliers.
   - Stimulus: op_a=0xFFFF, op_b=0.
   - Response: done after 2 cycles, result=0, ovf=0.
   - Stimulus: op_b=1.
   - Response: done after 5 cycles, result=0xFFFF, ovf=0.
4. Overflow paths.
   - Stimulus: op_a=0x8000, op_b=3 (lost path).
   - Response: result=0x8000, ovf=1.
   - Stimulus: op_a=0x6000, op_b=3 (carry path).
   - Response: result=0x2000, ovf=1.
   - Stimulus: 0x0100*0x0100.
   - Response: result=0, ovf=1, latency 29.
5. Handshake and abort.
   - Stimulus: start 7*9 and pulse start again at cycle 3.
   - Response: second start ignored, result=63.
   - Stimulus: sys_rst at cycle 4 of 0x1234*0x00FF.
   - Response: IDLE next cycle, no done pulse, result=0; a following 2*2 yields 4.
6. Signed mode (D16_MUL_SIGNED_EN).
   - Stimulus: signed_op=1, op_a=0xFFFD, op_b=5.
   - Response: result=0xFFF1, ovf=0, latency 13.
   - Stimulus: op_a=0x8000, op_b=0xFFFF.
   - Response: ovf=1.
